// File: rtl/skinny_round_ctrl_pkg.sv
// Shared definitions for the SKINNY round controller: FSM states, block geometry
// and the 6-bit round-constant LFSR step.
package skinny_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam int ROUNDS           = 40;
    localparam int ROUNDS_PER_CYCLE = 2;
    localparam int BEATS            = 4;
    localparam int RC_W             = 6;

    // One LFSR step: shift left, feed back rc[5]^rc[4]^1.
    function automatic logic [RC_W-1:0] rc_step(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_rc_lfsr.sv
// Round-constant LFSR: holds the constant state and exposes its one-step and
// two-step successors combinationally for the two rounds computed per cycle.
module skinny_rc_lfsr
    import skinny_round_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            adv_i,
    output logic [RC_W-1:0] step1_o,
    output logic [RC_W-1:0] step2_o
);

    logic [RC_W-1:0] rc_q;

    assign step1_o = rc_step(rc_q);
    assign step2_o = rc_step(step1_o);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rc_q <= '0;
        end else if (adv_i) begin
            rc_q <= step2_o;
        end
    end

endmodule

// File: rtl/skinny_round_ctrl.sv
// SKINNY round controller: sequences block load, the two-rounds-per-cycle cipher
// phase and block unload, driving the datapath shift/update enables.
module skinny_round_ctrl #(
    parameter int ROUND_CYCLES = skinny_round_ctrl_pkg::ROUNDS / skinny_round_ctrl_pkg::ROUNDS_PER_CYCLE,
    parameter int BEATS        = skinny_round_ctrl_pkg::BEATS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sse,
    output logic       senc,
    output logic       kse,
    output logic       kenc,
    output logic [5:0] constant,
    output logic [5:0] constant2,
    output logic       busy,
    output logic       done
);

    import skinny_round_ctrl_pkg::*;

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUND_CYCLES - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [RC_W-1:0] rc_step1, rc_step2;
    logic            in_acc, out_acc;

    assign in_acc  = (state_q == ST_LOAD) && in_valid;
    assign out_acc = (state_q == ST_OUT) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (in_acc && beat_q == BEAT_LAST) state_d = ST_ROUND;
            ST_ROUND: if (rnd_q == ROUND_LAST) state_d = ST_OUT;
            ST_OUT:   if (out_acc && beat_q == BEAT_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Beat counter is shared by LOAD and OUT; it always ends a phase at zero.
    always_comb begin
        beat_d = beat_q;
        rnd_d  = rnd_q;
        if (in_acc || out_acc) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
        end
        if (state_q == ST_ROUND) begin
            rnd_d = (rnd_q == ROUND_LAST) ? '0 : rnd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            rnd_q  <= '0;
        end else begin
            beat_q <= beat_d;
            rnd_q  <= rnd_d;
        end
    end

    skinny_rc_lfsr u_rc_lfsr (
        .clk     (clk),
        .rst     (rst),
        .clear_i ((state_q == ST_IDLE) && start),
        .adv_i   (state_q == ST_ROUND),
        .step1_o (rc_step1),
        .step2_o (rc_step2)
    );

    // in_ready/out_valid come from state only; handshakes gate just the enables.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sse       = 1'b0;
        senc      = 1'b0;
        kse       = 1'b0;
        kenc      = 1'b0;
        constant  = '0;
        constant2 = '0;
        done      = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                sse      = in_valid;
                kse      = in_valid;
            end
            ST_ROUND: begin
                senc      = 1'b1;
                kenc      = 1'b1;
                constant  = rc_step1;
                constant2 = rc_step2;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                sse       = out_ready;
                done      = out_ready && (beat_q == BEAT_LAST);
            end
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Self-checking bench for skinny_round_ctrl against a counting reference model
// of load beats, rounds and output beats.
module tb_skinny_round_ctrl;

    localparam int RC = 20;
    localparam int B  = 4;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic       in_ready, out_valid, sse, senc, kse, kenc, busy, done;
    logic [5:0] constant, constant2;

    int checks = 0;
    int errors = 0;

    // Reference model: how far the current block has progressed.
    bit m_busy;
    int m_loaded, m_rounds, m_out;
    logic [5:0] rc_seq [0:2*RC];

    skinny_round_ctrl #(.ROUND_CYCLES(RC), .BEATS(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sse       (sse),
        .senc      (senc),
        .kse       (kse),
        .kenc      (kenc),
        .constant  (constant),
        .constant2 (constant2),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // 0 idle, 1 loading, 2 cipher rounds, 3 unloading
    function automatic int phase();
        if (!m_busy) return 0;
        if (m_loaded < B) return 1;
        if (m_rounds < RC) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_loaded = 0; m_rounds = 0; m_out = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic s, input logic iv, input logic ordy,
                         output logic ov, output logic ir, output logic dn);
        int ph;
        @(negedge clk);
        rst = r; start = s; in_valid = iv; out_ready = ordy;
        #1;
        ph = phase();
        chk("busy",      8'(busy),      8'(ph != 0));
        chk("in_ready",  8'(in_ready),  8'(ph == 1));
        chk("out_valid", 8'(out_valid), 8'(ph == 3));
        chk("sse",       8'(sse),       8'((ph == 1 && iv) || (ph == 3 && ordy)));
        chk("kse",       8'(kse),       8'(ph == 1 && iv));
        chk("senc",      8'(senc),      8'(ph == 2));
        chk("kenc",      8'(kenc),      8'(ph == 2));
        chk("constant",  8'(constant),  (ph == 2) ? 8'(rc_seq[2*m_rounds+1]) : 8'h00);
        chk("constant2", 8'(constant2), (ph == 2) ? 8'(rc_seq[2*m_rounds+2]) : 8'h00);
        chk("done",      8'(done),      8'(ph == 3 && ordy && m_out == B - 1));
        ov = out_valid; ir = in_ready; dn = done;
        if (r) begin
            model_reset();
        end else begin
            case (ph)
                0: if (s) begin model_reset(); m_busy = 1; end
                1: if (iv) m_loaded++;
                2: m_rounds++;
                default: if (ordy) begin
                    m_out++;
                    if (m_out == B) m_busy = 0;
                end
            endcase
        end
    endtask

    // in_mode/out_mode: 0 always ready, 1 toggle / 3-cycle stall, 2 random.
    // noise: 0 none, 1 start held while busy, 2 random start while busy.
    task automatic run_block(input int in_mode, input int out_mode, input int noise,
                             input int abort_round,
                             output int first_ov, output int done_cnt, output int load_cyc);
        bit   started = 0;
        int   n = 0, idx = 0, lc = 0, oc = 0, ph;
        logic r, s, iv, ordy, ov, ir, dn;
        first_ov = -1; done_cnt = 0; load_cyc = 0;
        while (n < 300 && !(started && !m_busy)) begin
            ph   = phase();
            r    = 1'b0;
            s    = 1'b0;
            iv   = 1'($urandom);
            ordy = 1'($urandom);
            if (ph == 0) s = 1'b1;
            else if (noise == 1) s = 1'b1;
            else if (noise == 2) s = 1'($urandom);
            if (ph == 1) begin
                iv = (in_mode == 0) ? 1'b1 : (in_mode == 1) ? 1'(lc % 2 == 0) : 1'($urandom);
                lc++;
            end
            if (ph == 3) begin
                ordy = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? 1'(oc >= 3) : 1'($urandom);
                oc++;
            end
            if (ph == 2 && m_rounds == abort_round) r = 1'b1;
            cycle(r, s, iv, ordy, ov, ir, dn);
            if (ph == 0) started = 1;
            else idx++;
            if (ov && first_ov < 0) first_ov = idx;
            if (ir) load_cyc++;
            if (dn) done_cnt++;
            n++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $error("FAIL timeout block still busy after %0d cycles", n);
            model_reset();
        end
    endtask

    initial begin
        int   fo, dc, lcyc;
        logic ov, ir, dn;
        logic [5:0] r6;

        r6 = 6'h00;
        rc_seq[0] = r6;
        for (int k = 1; k <= 2 * RC; k++) begin
            r6 = 6'(((r6 << 1) & 6'h3f) | ((((r6 >> 5) ^ (r6 >> 4)) & 6'h01) ^ 6'h01));
            rc_seq[k] = r6;
        end

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);

        // Reset state, then idle with noisy handshakes
        cycle(1'b1, 1'b0, 1'b1, 1'b1, ov, ir, dn);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, ov, ir, dn);

        // Back-to-back block: latency, constants, single done
        run_block(0, 0, 0, -1, fo, dc, lcyc);
        chk("latency", 8'(fo), 8'(1 + B + RC));
        chk("done_count_b2b", 8'(dc), 8'd1);
        chk("load_cycles_b2b", 8'(lcyc), 8'(B));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ov, ir, dn);

        // Alternating in_valid: 4 beats over 7 load cycles
        run_block(1, 0, 0, -1, fo, dc, lcyc);
        chk("load_cycles_toggle", 8'(lcyc), 8'd7);
        chk("done_count_toggle", 8'(dc), 8'd1);

        // Output stall for 3 cycles
        run_block(0, 1, 0, -1, fo, dc, lcyc);
        chk("done_count_stall", 8'(dc), 8'd1);

        // Reset in round cycle 10, then a fresh block right after release
        run_block(0, 0, 0, 10, fo, dc, lcyc);
        chk("done_count_abort", 8'(dc), 8'd0);
        run_block(0, 0, 0, -1, fo, dc, lcyc);
        chk("latency_after_abort", 8'(fo), 8'(1 + B + RC));
        chk("done_count_after_abort", 8'(dc), 8'd1);

        // start held through LOAD, ROUND and the done cycle
        run_block(0, 0, 1, -1, fo, dc, lcyc);
        chk("done_count_start_noise", 8'(dc), 8'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ov, ir, dn);
        chk("idle_after_noise", 8'(ir | ov), 8'd0);

        // Randomized handshakes and start noise
        for (int t = 0; t < 6; t++) begin
            run_block(2, 2, 2, -1, fo, dc, lcyc);
            chk("done_count_random", 8'(dc), 8'd1);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, ov, ir, dn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
